inv_tester: RTL and testbench

INV_TESTER -- requirements
Module: inv_tester

---
 rtl/inv_tester.sv | 89 ++++++++
 tb/tb_inv_tester.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_tester.sv
// Sweeps every WIDTH-bit vector into an external inverter and checks dut_y == ~dut_a.
// Each vector is held for SETTLE cycles and then checked for one cycle.
module inv_tester #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       fail_count,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic [WIDTH-1:0] first_fail_got,
  output logic [1:0]       state_dbg
);

  // start is a level sampled only in IDLE/DONE; there is no ready handshake, and
  // a start seen in SETTLE or CHECK is dropped, not queued.
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       mismatch;

  assign mismatch  = (dut_y != ~dut_a);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      dut_a          <= '0;
      wait_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_SETTLE;
            dut_a          <= '0;
            wait_cnt       <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            first_fail_got <= '0;
          end
        end
        S_SETTLE: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) state <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            // fail_count saturates and never wraps, so zero means no earlier mismatch
            if (fail_count == 8'd0) begin
              first_fail_vec <= dut_a;
              first_fail_got <= dut_y;
            end
          end
          if (dut_a == {WIDTH{1'b1}}) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == 8'd0) && !mismatch;
          end else begin
            state    <= S_SETTLE;
            dut_a    <= dut_a + WIDTH'(1);
            wait_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_tester.sv
// Directed bench for inv_tester: a behavioural inverter with selectable faults
// drives dut_y, and each task checks one scenario against hand-computed values.
module tb_inv_tester;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dut_a;
  logic [3:0] dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_count;
  logic [3:0] first_fail_vec;
  logic [3:0] first_fail_got;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0 good inverter, 1 stuck at zero, 2 wrong value at 0xA

  inv_tester #(.WIDTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_a(dut_a), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_vec(first_fail_vec), .first_fail_got(first_fail_got),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dut_y = ~dut_a;
    if (mode == 1) dut_y = 4'h0;
    else if (mode == 2 && dut_a == 4'hA) dut_y = 4'h4;
  end

  // driver tasks
  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (!done && cycles < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({dut_a, busy, done, pass, fail_count, first_fail_vec, first_fail_got, state_dbg} !== '0) begin
      errors++;
      $display("FAIL %s outputs: dut_a=%h busy=%b done=%b pass=%b fc=%0d vec=%h got=%h st=%0d, want all 0",
               tag, dut_a, busy, done, pass, fail_count, first_fail_vec, first_fail_got, state_dbg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("idle_hold");
  endtask

  task automatic test_pass_sweep();
    int cyc; bit bok;
    mode = 0;
    start_run();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL pass_busy busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(cyc, bok);
    checks++;
    if (cyc !== 48) begin errors++; $display("FAIL pass_cycles got %0d want 48", cyc); end
    checks++;
    if (!bok) begin errors++; $display("FAIL pass_busy_low busy dropped before done"); end
    checks++;
    if ({done, pass, busy, fail_count, dut_a} !== {1'b1, 1'b1, 1'b0, 8'd0, 4'hF}) begin
      errors++;
      $display("FAIL pass_result done=%b pass=%b busy=%b fc=%0d dut_a=%h want 1 1 0 0 f",
               done, pass, busy, fail_count, dut_a);
    end
    repeat (5) @(posedge clk);
    #1 checks++;
    if ({done, pass, busy, fail_count, dut_a, state_dbg} !== {1'b1, 1'b1, 1'b0, 8'd0, 4'hF, 2'd3}) begin
      errors++;
      $display("FAIL done_hold done=%b pass=%b busy=%b fc=%0d dut_a=%h st=%0d want 1 1 0 0 f 3",
               done, pass, busy, fail_count, dut_a, state_dbg);
    end
  endtask

  task automatic test_stuck_zero();
    int cyc; bit bok;
    mode = 1;
    start_run();
    wait_done(cyc, bok);
    checks++;
    if ({cyc == 48, done, pass, fail_count, first_fail_vec, first_fail_got} !==
        {1'b1, 1'b1, 1'b0, 8'd15, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL stuck_zero cyc=%0d done=%b pass=%b fc=%0d vec=%h got=%h want 48 1 0 15 0 0",
               cyc, done, pass, fail_count, first_fail_vec, first_fail_got);
    end
  endtask

  task automatic test_single_fault();
    int cyc; bit bok;
    mode = 2;
    start_run();
    wait_done(cyc, bok);
    checks++;
    if ({done, pass, fail_count, first_fail_vec, first_fail_got} !==
        {1'b1, 1'b0, 8'd1, 4'hA, 4'h4}) begin
      errors++;
      $display("FAIL single_fault done=%b pass=%b fc=%0d vec=%h got=%h want 1 0 1 a 4",
               done, pass, fail_count, first_fail_vec, first_fail_got);
    end
  endtask

  // entered from the failing DONE left by test_single_fault
  task automatic test_restart_from_done();
    int cyc; bit bok;
    mode = 0;
    start_run();
    checks++;
    if ({busy, done, pass, fail_count, first_fail_vec, first_fail_got, dut_a} !==
        {1'b1, 1'b0, 1'b0, 8'd0, 4'h0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL restart_clear busy=%b done=%b pass=%b fc=%0d vec=%h got=%h dut_a=%h want 1 0 0 0 0 0 0",
               busy, done, pass, fail_count, first_fail_vec, first_fail_got, dut_a);
    end
    wait_done(cyc, bok);
    checks++;
    if ({cyc == 48, pass, fail_count} !== {1'b1, 1'b1, 8'd0}) begin
      errors++; $display("FAIL restart_result cyc=%0d pass=%b fc=%0d want 48 1 0", cyc, pass, fail_count);
    end
  endtask

  task automatic test_start_ignored();
    int cyc; bit bok;
    mode = 0;
    start_run();
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if ({busy, dut_a} !== {1'b1, 4'h3}) begin
      errors++; $display("FAIL ignore_mid busy=%b dut_a=%h want 1 3", busy, dut_a);
    end
    wait_done(cyc, bok);
    checks++;
    if (cyc + 10 !== 48 || pass !== 1'b1) begin
      errors++; $display("FAIL ignore_total cycles=%0d pass=%b want 48 1", cyc + 10, pass);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit bok;
    mode = 1;
    start_run();
    repeat (20) @(posedge clk);
    #1 checks++;
    if (fail_count !== 8'd6 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_partial fc=%0d busy=%b want 6 1", fail_count, busy);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("reset_async");
    @(negedge clk) rst = 1'b0;
    mode = 0;
    start_run();
    wait_done(cyc, bok);
    checks++;
    if ({cyc == 48, done, pass, fail_count, first_fail_vec, first_fail_got} !==
        {1'b1, 1'b1, 1'b1, 8'd0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL after_reset cyc=%0d done=%b pass=%b fc=%0d vec=%h got=%h want 48 1 1 0 0 0",
               cyc, done, pass, fail_count, first_fail_vec, first_fail_got);
    end
  endtask

  initial begin
    test_reset();
    test_pass_sweep();
    test_stuck_zero();
    test_single_fault();
    test_restart_from_done();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
